// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the PC register's next value, issues one
// instruction-memory read at a time and hands each fetched word to decode.
module fetch_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_d,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  typedef enum logic [2:0] {StBoot, StReq, StWaitRsp, StHold, StFault} state_e;

  state_e            state_q, state_d;
  logic              boot_q;
  logic              kill_q, kill_d;
  logic [ILEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic              redirect_bad;

  assign redirect_bad  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign imem_req_addr = pc_q;
  assign inst_data     = data_q;
  assign inst_pc       = ipc_q;
  assign fetch_fault   = (state_q == StFault);

  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    data_d         = data_q;
    ipc_d          = ipc_q;
    pc_d           = pc_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (state_q)
      // boot_q delays the first request by one cycle to match the PC register's reset hold
      StBoot: begin
        if (boot_q) state_d = StReq;
      end
      StReq: begin
        imem_req_valid = !redirect_valid;
        if (redirect_bad) begin
          state_d = StFault;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (imem_req_ready) begin
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (redirect_bad) begin
          state_d = StFault;
        end else begin
          if (redirect_valid) pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            if (kill_q || redirect_valid) begin
              kill_d  = 1'b0;
              state_d = StReq;
            end else begin
              data_d  = imem_rsp_data;
              ipc_d   = pc_q;
              state_d = StHold;
            end
          end else if (redirect_valid) begin
            // Response still in flight: remember to drop it when it lands
            kill_d = 1'b1;
          end
        end
      end
      StHold: begin
        inst_valid = !redirect_valid;
        if (redirect_bad) begin
          state_d = StFault;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = StReq;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StBoot;
      boot_q  <= 1'b0;
      kill_q  <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b1;
      kill_q  <= kill_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule
